// File: rtl/err_collector_pkg.sv
// err_collector_pkg: shared FSM states, mode encoding and accumulator width helper
package err_collector_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic {MODE_SQ = 1'b0, MODE_ABS = 1'b1} mode_t;
  function automatic int acc_w(input int dw, input int seq_len);
    return 2 * dw + 2 + $clog2(seq_len);
  endfunction
endpackage

// File: rtl/err_lane.sv
// err_lane: one channel of subtract/square-or-abs/accumulate/saturate (peak tracking under ERR_COLLECTOR_MC_PEAK_EN)
module err_lane
  import err_collector_pkg::*;
#(
  parameter int DW      = 29,
  parameter int SEQ_LEN = 131072,
  parameter int OW      = 64,
  parameter int SHIFT   = 14
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          mode,
  input  logic          in_valid,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] data_ref,
`ifdef ERR_COLLECTOR_MC_PEAK_EN
  output logic [DW:0]   peak_out,
`endif
  output logic [OW-1:0] data_out
);
  localparam int ACC_W = acc_w(DW, SEQ_LEN);
  localparam int SW = ACC_W > OW ? ACC_W : OW;
  logic signed [DW:0]     d1;
  logic signed [2*DW+1:0] dx;
  logic [DW:0]            ad;
  logic [2*DW+1:0]        e2;
  logic [ACC_W-1:0]       acc;
  logic [SW-1:0]          sh;
  logic [OW-1:0]          sat;
  logic                   v1, v2;
  assign dx = d1;
  assign ad = d1 < 0 ? -d1 : d1;
  assign sh = SW'(acc) >> SHIFT;
  assign sat = sh > SW'({OW{1'b1}}) ? '1 : sh[OW-1:0];
  // two-stage error pipeline feeding the accumulator; result is only presented on load
  always_ff @(posedge clk) begin
    if (!rstn) begin
      d1       <= '0;
      v1       <= 1'b0;
      e2       <= '0;
      v2       <= 1'b0;
      acc      <= '0;
      data_out <= '0;
    end else begin
      d1       <= $signed({1'b0, data_ref}) - $signed({1'b0, data_in});
      v1       <= in_valid;
      e2       <= mode == MODE_ABS ? (2*DW+2)'(ad) : $unsigned(dx * dx);
      v2       <= v1;
      acc      <= clr ? '0 : v2 ? acc + ACC_W'(e2) : acc;
      data_out <= load ? sat : '0;
    end
  end
`ifdef ERR_COLLECTOR_MC_PEAK_EN
  logic [DW:0] a2, pk;
  // running max of |d| aligned with the accumulator stage
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a2       <= '0;
      pk       <= '0;
      peak_out <= '0;
    end else begin
      a2       <= ad;
      pk       <= clr ? '0 : (v2 && a2 > pk) ? a2 : pk;
      peak_out <= load ? pk : '0;
    end
  end
`endif
endmodule

// File: rtl/err_collector_mc.sv
// err_collector_mc: multi-channel error-energy collector; optional peak_out via ERR_COLLECTOR_MC_PEAK_EN
module err_collector_mc
  import err_collector_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 29,
  parameter int SEQ_LEN = 131072,
  parameter int OW      = 64,
  parameter int SHIFT   = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH*DW-1:0] data_ref,
  output logic [NCH*OW-1:0] data_out,
`ifdef ERR_COLLECTOR_MC_PEAK_EN
  output logic [NCH*(DW+1)-1:0] peak_out,
`endif
  output logic              data_valid,
  output logic              busy
);
  localparam int CW = $clog2(SEQ_LEN);
  state_t        state;
  mode_t         mode_q;
  logic [CW-1:0] cnt;
  logic          clr, samp, load;
  assign clr  = state == IDLE && start;
  assign samp = state == RUN && in_valid;
  assign load = state == DONE;
  // measurement sequencer; cnt counts samples in RUN and the two drain cycles in DRAIN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      mode_q     <= MODE_SQ;
      cnt        <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= state == DONE;
      busy       <= state != IDLE || start;
      case (state)
        IDLE: if (start) begin
          state  <= RUN;
          mode_q <= mode_t'(mode);
          cnt    <= '0;
        end
        RUN: if (in_valid) begin
          cnt <= cnt == CW'(SEQ_LEN - 1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(SEQ_LEN - 1)) state <= DRAIN;
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    err_lane #(.DW(DW), .SEQ_LEN(SEQ_LEN), .OW(OW), .SHIFT(SHIFT)) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (clr),
      .mode     (mode_q),
      .in_valid (samp),
      .load     (load),
      .data_in  (data_in[k*DW +: DW]),
      .data_ref (data_ref[k*DW +: DW]),
`ifdef ERR_COLLECTOR_MC_PEAK_EN
      .peak_out (peak_out[k*(DW+1) +: DW+1]),
`endif
      .data_out (data_out[k*OW +: OW])
    );
  end
endmodule
